slice_alu: RTL and testbench
============================

Name: slice_alu

Overview:
- Parametrised, multi-cycle successor to the core 8-bit ALU.
- Processes arithmetic and logic ops one SLICE_W-bit slice per clock, LSB slice first, the way the original 4-bit-datapath CPU does.
- Works at any DATA_W, so the same block serves 8-bit accumulator ops and 16-bit ADD HL/SP ops.
- Sits beside the CPU datapath; the microsequencer starts an op, waits for done, then writes back the result and flags.

Parameters:
- DATA_W, 8, operand/result width; must be a multiple of SLICE_W.
- SLICE_W, 4, bits processed per cycle.
- H_BIT, 3, half-carry is the carry/borrow out of this bit; (H_BIT+1) must be a multiple of SLICE_W, and H_BIT < DATA_W-1.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, reset, synchronous, active-low.
- start, in, 1, request new op; accepted only when busy=0.
- op, in, 3, 0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 XOR, 6 OR, 7 CP.
- op_a, in, DATA_W, accumulator / minuend.
- op_b, in, DATA_W, operand / subtrahend.
- flags_in, in, 4, {Z,N,H,C}; only C is used (ADC/SBC carry-in).
- busy, out, 1, op in progress.
- done, out, 1, one-cycle pulse; result/flags valid.
- result, out, DATA_W, registered result.
- flags_out, out, 4, registered {Z,N,H,C}.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; busy=0, done=0, result=0, flags_out=0, slice index=0. Applies mid-operation; the in-flight op is discarded and produces no done.
- N = DATA_W/SLICE_W.
- States: IDLE, RUN, DONE.
- Accept: at an edge with start=1 and state IDLE or DONE:
  - latch op, op_a, op_b, and carry-in = flags_in[0] for ADC/SBC (0 otherwise);
  - state→RUN, idx=0, busy=1, done=0.
- start with busy=1 is ignored; nothing is queued.
- RUN: each edge computes slice idx from the latched operands and the carry register, then idx++.
  - Result slice and running-zero accumulator are updated.
  - At the slice ending at bit H_BIT, H is captured from that slice's carry/borrow out.
  - On the edge processing slice N-1: result, flags_out and done=1 are updated; state→DONE; busy=0.
- Latency: done is high exactly N cycles after the accept edge (8-bit default: 2; 16-bit: 4).
- DONE lasts one cycle, then IDLE unless start is accepted in that same cycle. Back-to-back ops therefore issue every N+1 cycles at most.
- result and flags_out hold their values until the next done or reset. They never show partial values.
- Arithmetic: all modulo 2^DATA_W.
  - ADD/ADC: a+b+cin. C = carry out of MSB; H = carry out of H_BIT; N=0.
  - SUB/SBC/CP: a-b-cin. C = borrow out of MSB; H = borrow out of H_BIT; N=1.
  - CP: flags as SUB; result = latched op_a (unchanged).
  - AND: H=1, N=0, C=0. XOR/OR: H=0, N=0, C=0.
  - Z = 1 iff the full-width computed value is 0. For CP this is the difference.
- Inputs are sampled only at accept. Changes to op_a/op_b/flags_in during RUN have no effect.

Test Plan:
- Defaults: ADD a=0x3A b=0xC6, start 1 cycle → done 2 cycles later; result=0x00, flags=1011 (Z,H,C); busy high for exactly 2 cycles.
- Defaults: SBC a=0x10 b=0x00 flags_in C=1 → result=0x0F, flags=0110 (N,H); same op with C=0 → 0x10, flags=0100.
- Defaults: CP a=0x20 b=0x30 → result=0x20, flags=0101 (N,C). AND a=0xF0 b=0x0F → result=0x00, flags=1010.
- DATA_W=16, H_BIT=11: ADD 0x0FFF+0x0001 → done 4 cycles after accept; result=0x1000, flags=0010. ADD 0xFFFF+0x0001 → 0x0000, flags=1011.
- Handshake: start held high continuously with changing operands → accepts every N+1 cycles only. Operands changed while busy are ignored. Start in DONE cycle is accepted, giving a new done N cycles later.
- rst_n=0 for one edge mid-RUN → busy=0, done=0, result=0, flags=0 next cycle, no stray done. A new op afterwards completes correctly.

Source files
------------

// File: rtl/slice_alu.sv
// Multi-cycle ALU that walks the operands one SLICE_W-bit slice per clock, LSB first.
// Used beside the CPU datapath for both 8-bit accumulator ops and 16-bit register-pair adds.
module slice_alu #(
  parameter int DATA_W  = 8,
  parameter int SLICE_W = 4,
  parameter int H_BIT   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [3:0]        flags_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags_out
);

  localparam int N     = DATA_W / SLICE_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int H_IDX = (H_BIT + 1) / SLICE_W - 1;

  localparam logic [IDX_W-1:0] LAST_SLICE = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] H_SLICE    = IDX_W'(H_IDX);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_SBC = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_CP  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [3:0]          flags_q, flags_d;

  logic [2:0]          op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic                cy_q, cy_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                zero_q, zero_d;
  logic                h_q, h_d;

  logic                is_sub;
  logic                is_arith;
  logic [SLICE_W-1:0]  a_s, b_s, slice_v;
  logic [SLICE_W:0]    arith_v;
  logic                cout;
  logic                slice_z;
  logic                h_final;
  int                  bit_lo;

  logic                unused_flags;
  assign unused_flags = ^flags_in[3:1];

  // Returns {carry/borrow out, slice value}; a borrow shows up as the top bit of the wrapped difference.
  function automatic logic [SLICE_W:0] slice_arith(input logic [SLICE_W-1:0] a,
                                                   input logic [SLICE_W-1:0] b,
                                                   input logic               cin,
                                                   input logic               sub);
    logic [SLICE_W:0] ae, be, ce;
    ae = {1'b0, a};
    be = {1'b0, b};
    ce = {{SLICE_W{1'b0}}, cin};
    slice_arith = sub ? (ae - be - ce) : (ae + be + ce);
  endfunction

  always_comb begin
    is_sub   = (op_q == OP_SUB) || (op_q == OP_SBC) || (op_q == OP_CP);
    is_arith = (op_q != OP_AND) && (op_q != OP_XOR) && (op_q != OP_OR);
    bit_lo   = int'(idx_q) * SLICE_W;
    a_s      = a_q[bit_lo +: SLICE_W];
    b_s      = b_q[bit_lo +: SLICE_W];
    arith_v  = slice_arith(a_s, b_s, cy_q, is_sub);

    case (op_q)
      OP_AND:  slice_v = a_s & b_s;
      OP_XOR:  slice_v = a_s ^ b_s;
      OP_OR:   slice_v = a_s | b_s;
      default: slice_v = arith_v[SLICE_W-1:0];
    endcase

    cout    = is_arith & arith_v[SLICE_W];
    slice_z = (slice_v == '0);

    case (op_q)
      OP_AND:         h_final = 1'b1;
      OP_XOR, OP_OR:  h_final = 1'b0;
      default:        h_final = (idx_q == H_SLICE) ? cout : h_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    flags_d  = flags_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cy_d     = cy_q;
    acc_d    = acc_q;
    zero_d   = zero_q;
    h_d      = h_q;

    case (state_q)
      RUN: begin
        acc_d[bit_lo +: SLICE_W] = slice_v;
        cy_d   = cout;
        zero_d = zero_q & slice_z;
        if (idx_q == H_SLICE) h_d = cout;
        idx_d  = idx_q + 1'b1;
        if (idx_q == LAST_SLICE) begin
          state_d  = DONE;
          idx_d    = '0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = (op_q == OP_CP) ? a_q : acc_d;
          flags_d  = {zero_q & slice_z, is_sub, h_final, cout};
        end
      end
      default: begin
        // IDLE and DONE both accept; DONE falls back to IDLE after its single cycle.
        state_d = IDLE;
        busy_d  = 1'b0;
        if (start) begin
          op_d    = op;
          a_d     = op_a;
          b_d     = op_b;
          cy_d    = ((op == OP_ADC) || (op == OP_SBC)) & flags_in[0];
          acc_d   = '0;
          zero_d  = 1'b1;
          h_d     = 1'b0;
          idx_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q   <= op_d;
    a_q    <= a_d;
    b_q    <= b_d;
    cy_q   <= cy_d;
    acc_q  <= acc_d;
    zero_q <= zero_d;
    h_q    <= h_d;
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign flags_out = flags_q;

endmodule

// File: tb/tb_slice_alu.sv
// Scoreboard bench for slice_alu: an 8-bit default instance and a 16-bit (H_BIT=11) instance.
module tb_slice_alu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start8, start16;
  logic [2:0]  op8, op16;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic [3:0]  fl8, fl16;
  logic        busy8, done8, busy16, done16;
  logic [7:0]  result8;
  logic [15:0] result16;
  logic [3:0]  flags8, flags16;

  slice_alu dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .op_a(a8), .op_b(b8),
    .flags_in(fl8), .busy(busy8), .done(done8), .result(result8), .flags_out(flags8)
  );

  slice_alu #(.DATA_W(16), .SLICE_W(4), .H_BIT(11)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .op(op16), .op_a(a16), .op_b(b16),
    .flags_in(fl16), .busy(busy16), .done(done16), .result(result16), .flags_out(flags16)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  fl;
    int          acc;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  exp_t e8, e16;
  int   bc8 = 0;
  int   bc16 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: whole-word integer arithmetic, returns {Z,N,H,C, result}.
  function automatic logic [19:0] model(input int w, input int hb, input logic [2:0] op,
                                        input logic [15:0] a, input logic [15:0] b, input logic cin);
    int unsigned m, hm, av, bv, ci, r;
    int d, dh;
    logic z, n, h, c;
    m  = (32'd1 << w) - 1;
    hm = (32'd1 << (hb + 1)) - 1;
    av = {16'd0, a} & m;
    bv = {16'd0, b} & m;
    ci = ((op == 3'd1) || (op == 3'd3)) ? {31'd0, cin} : 0;
    n = 1'b0; h = 1'b0; c = 1'b0; r = 0;
    case (op)
      3'd0, 3'd1: begin
        r = av + bv + ci;
        c = ((r >> w) & 1) != 0;
        h = ((((av & hm) + (bv & hm) + ci) >> (hb + 1)) & 1) != 0;
        r = r & m;
      end
      3'd2, 3'd3, 3'd7: begin
        d  = int'(av) - int'(bv) - int'(ci);
        dh = int'(av & hm) - int'(bv & hm) - int'(ci);
        c  = d < 0;
        h  = dh < 0;
        n  = 1'b1;
        r  = unsigned'(d) & m;
      end
      3'd4: begin r = av & bv; h = 1'b1; end
      3'd5: r = av ^ bv;
      default: r = av | bv;
    endcase
    z = (r == 0);
    if (op == 3'd7) r = av;
    return {z, n, h, c, r[15:0]};
  endfunction

  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) chk("stray_done8", 1, 0);
      else begin
        e8 = q8.pop_front();
        chk("res8", {24'd0, result8}, {16'd0, e8.res});
        chk("flags8", {28'd0, flags8}, {28'd0, e8.fl});
        chk("latency8", cyc - e8.acc, 2);
      end
      chk("busy_len8", bc8, 2);
      bc8 = 0;
    end else if (busy8) bc8++;
    else bc8 = 0;

    if (done16) begin
      if (q16.size() == 0) chk("stray_done16", 1, 0);
      else begin
        e16 = q16.pop_front();
        chk("res16", {16'd0, result16}, {16'd0, e16.res});
        chk("flags16", {28'd0, flags16}, {28'd0, e16.fl});
        chk("latency16", cyc - e16.acc, 4);
      end
      chk("busy_len16", bc16, 4);
      bc16 = 0;
    end else if (busy16) bc16++;
    else bc16 = 0;
  end

  // Called at a negedge; returns at the negedge after the accept edge, operands then scrambled.
  task automatic issue(input bit w16, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input bit use_exp, input logic [15:0] xres, input logic [3:0] xfl);
    int guard;
    exp_t e;
    guard = 0;
    while ((w16 ? busy16 : busy8) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("busy_timeout", 1, 0);
    if (use_exp) begin
      e.res = xres;
      e.fl  = xfl;
    end else begin
      {e.fl, e.res} = model(w16 ? 16 : 8, w16 ? 11 : 3, op, a, b, cin);
    end
    e.acc = cyc + 1;
    if (w16) begin
      op16 = op; a16 = a; b16 = b; fl16 = {3'b101, cin};
      q16.push_back(e);
      start16 = 1'b1;
    end else begin
      op8 = op; a8 = a[7:0]; b8 = b[7:0]; fl8 = {3'b101, cin};
      q8.push_back(e);
      start8 = 1'b1;
    end
    @(negedge clk);
    start8 = 1'b0;
    start16 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); fl8 = 4'($urandom);
    a16 = 16'($urandom); b16 = 16'($urandom); fl16 = 4'($urandom);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((q8.size() != 0 || q16.size() != 0) && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("drain", q8.size() + q16.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    exp_t e;
    rst_n = 1'b0;
    start8 = 1'b0; start16 = 1'b0;
    op8 = '0; op16 = '0; a8 = '0; b8 = '0; a16 = '0; b16 = '0; fl8 = '0; fl16 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    chk("rst_busy8", {31'd0, busy8}, 0);
    chk("rst_done8", {31'd0, done8}, 0);
    chk("rst_res8", {24'd0, result8}, 0);
    chk("rst_flags8", {28'd0, flags8}, 0);
    chk("rst_busy16", {31'd0, busy16}, 0);
    chk("rst_res16", {16'd0, result16}, 0);

    // Back-to-back: each accept lands in the previous op's DONE cycle.
    issue(0, 3'd0, 16'h3A, 16'hC6, 1'b0, 1, 16'h00, 4'b1011);
    issue(0, 3'd3, 16'h10, 16'h00, 1'b1, 1, 16'h0F, 4'b0110);
    issue(0, 3'd3, 16'h10, 16'h00, 1'b0, 1, 16'h10, 4'b0100);
    issue(0, 3'd7, 16'h20, 16'h30, 1'b0, 1, 16'h20, 4'b0101);
    issue(0, 3'd4, 16'hF0, 16'h0F, 1'b0, 1, 16'h00, 4'b1010);
    issue(1, 3'd0, 16'h0FFF, 16'h0001, 1'b0, 1, 16'h1000, 4'b0010);
    issue(1, 3'd0, 16'hFFFF, 16'h0001, 1'b0, 1, 16'h0000, 4'b1011);

    for (int i = 0; i < 24; i++) begin
      issue(0, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 1'($urandom), 0, '0, '0);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    for (int i = 0; i < 12; i++) begin
      issue(1, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 1'($urandom), 0, '0, '0);
    end
    drain();

    // start held high with operands changing every cycle.
    prev = -1;
    start8 = 1'b1;
    for (int i = 0; i < 30; i++) begin
      op8 = 3'($urandom_range(0, 7));
      a8 = 8'($urandom); b8 = 8'($urandom); fl8 = 4'($urandom);
      if (!busy8) begin
        {e.fl, e.res} = model(8, 3, op8, {8'd0, a8}, {8'd0, b8}, fl8[0]);
        e.acc = cyc + 1;
        q8.push_back(e);
        if (prev >= 0) chk("accept_spacing", cyc + 1 - prev, 3);
        prev = cyc + 1;
      end
      @(negedge clk);
    end
    start8 = 1'b0;
    drain();

    issue(0, 3'd0, 16'h12, 16'h34, 1'b0, 1, 16'h46, 4'b0000);
    drain();

    // Reset lands while the op is in RUN.
    issue(0, 3'd1, 16'h99, 16'h11, 1'b1, 0, '0, '0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    q8.delete();
    chk("midrst_busy8", {31'd0, busy8}, 0);
    chk("midrst_done8", {31'd0, done8}, 0);
    chk("midrst_res8", {24'd0, result8}, 0);
    chk("midrst_flags8", {28'd0, flags8}, 0);
    chk("midrst_res16", {16'd0, result16}, 0);
    repeat (6) @(negedge clk);

    issue(0, 3'd0, 16'h3A, 16'hC6, 1'b0, 1, 16'h00, 4'b1011);
    issue(0, 3'd2, 16'h05, 16'h07, 1'b0, 0, '0, '0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
